sync_fifo: RTL

//  Single-clock FIFO that stores the data words its producer pushes and returns them to its consumer in order.
//  It generates the full/empty status that the design-side push/pop checker samples every clock.
//  It sits directly behind that checker, on the same clk and interface signals (push, pop, full, empty).

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_mem_1r1w.sv | 41 ++++
 rtl/sync_fifo.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO and its storage.
package fifo_pkg;

  localparam int DW_DEFAULT     = 8;
  localparam int DEPTH_DEFAULT  = 16;
  localparam int AF_LVL_DEFAULT = 14;

  // Error classification used when reporting the sticky error flags
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_OVF,
    ERR_UDF
  } fifo_err_e;

  // Address width for a given depth, never less than one bit
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_mem_1r1w.sv
// DW x DEPTH storage with synchronous write and registered, enabled read.
// Kept as its own module so it can be replaced by a RAM macro.
module fifo_mem_1r1w
  import fifo_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = clog2_safe(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wrEn,
  input  logic [AW-1:0] i_wrAddr,
  input  logic [DW-1:0] i_wrData,
  input  logic          i_rdEn,
  input  logic [AW-1:0] i_rdAddr,
  output logic [DW-1:0] o_rdData
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdData;

  // Storage array is never reset; only written on an accepted push
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  // Read register returns the old word when reading and writing the same entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdData <= '0;
    end else if (i_rdEn) begin
      r_rdData <= r_mem[i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags and sticky
// overflow/underflow error reporting.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int AF_LVL = AF_LVL_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  output logic [DW-1:0]              rdata,
  output logic                       rvalid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf_err,
  output logic                       udf_err,
  input  logic                       err_clr
);

  localparam int AW = clog2_safe(DEPTH);

  // Extra MSB tells a full FIFO apart from an empty one after wrap
  typedef logic [AW:0] ptr_t;

  localparam ptr_t AF_P = ptr_t'(AF_LVL);

  ptr_t r_wrPtr;
  ptr_t r_rdPtr;
  ptr_t r_count;
  logic r_full;
  logic r_empty;
  logic r_almostFull;
  logic r_rvalid;
  logic r_ovfErr;
  logic r_udfErr;

  logic w_pushOk;
  logic w_popOk;
  ptr_t w_wrPtrNext;
  ptr_t w_rdPtrNext;
  ptr_t w_countNext;

  // Accept decisions use the registered flags; a pop frees room for a push when full
  always_comb begin
    w_popOk     = pop && !r_empty;
    w_pushOk    = push && (!r_full || w_popOk);
    w_wrPtrNext = w_pushOk ? (r_wrPtr + ptr_t'(1)) : r_wrPtr;
    w_rdPtrNext = w_popOk  ? (r_rdPtr + ptr_t'(1)) : r_rdPtr;
    w_countNext = w_wrPtrNext - w_rdPtrNext;
  end

  // Pointers, occupancy and flags all come from the next pointers so they never disagree
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_almostFull <= 1'b0;
      r_rvalid     <= 1'b0;
    end else begin
      r_wrPtr      <= w_wrPtrNext;
      r_rdPtr      <= w_rdPtrNext;
      r_count      <= w_countNext;
      r_full       <= (w_wrPtrNext[AW] != w_rdPtrNext[AW]) &&
                      (w_wrPtrNext[AW-1:0] == w_rdPtrNext[AW-1:0]);
      r_empty      <= (w_wrPtrNext == w_rdPtrNext);
      r_almostFull <= (w_countNext >= AF_P);
      r_rvalid     <= w_popOk;
    end
  end

  // Sticky errors; a new error in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovfErr <= 1'b0;
      r_udfErr <= 1'b0;
    end else begin
      if (push && !w_pushOk) begin
        r_ovfErr <= 1'b1;
      end else if (err_clr) begin
        r_ovfErr <= 1'b0;
      end
      if (pop && !w_popOk) begin
        r_udfErr <= 1'b1;
      end else if (err_clr) begin
        r_udfErr <= 1'b0;
      end
    end
  end

  fifo_mem_1r1w #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .i_wrEn   (w_pushOk),
    .i_wrAddr (r_wrPtr[AW-1:0]),
    .i_wrData (wdata),
    .i_rdEn   (w_popOk),
    .i_rdAddr (r_rdPtr[AW-1:0]),
    .o_rdData (rdata)
  );

  assign rvalid      = r_rvalid;
  assign full        = r_full;
  assign empty       = r_empty;
  assign almost_full = r_almostFull;
  assign count       = r_count;
  assign ovf_err     = r_ovfErr;
  assign udf_err     = r_udfErr;

endmodule
